// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and helpers for the stream demultiplexer.
//   ERR_CNT_W / ERR_CNT_MAX : width and saturation value of the drop counter
//   clog2_min1()            : select width for a given channel count (>= 1)
package stream_demux_pkg;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Bits needed to index n channels; a single channel still gets one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer/consumer handshake bundle for stream_demux.
//   in_data/in_sel/in_valid/in_ready : single input stream
//   out_data/out_valid/out_ready     : N output channels, channel k at [k*W +: W]
//   in_bcast                         : only when STREAM_DEMUX_BROADCAST_EN is defined
// modport slave  : the demux side
// modport master : the producer + consumers side
interface stream_demux_if #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int S = 2
);
  logic [W-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
`ifdef STREAM_DEMUX_BROADCAST_EN
  logic           in_bcast;

  modport slave (
    input  in_data, in_sel, in_valid, in_bcast, out_ready,
    output in_ready, out_data, out_valid
  );
  modport master (
    output in_data, in_sel, in_valid, in_bcast, out_ready,
    input  in_ready, out_data, out_valid
  );
`else
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
`endif
endinterface

// File: rtl/stream_demux_slot.sv
// demux_slot: one output channel's holding register.
//   clk, reset : clock, asynchronous active-high reset
//   load, din  : write din into the slot at the next edge
//   ready      : consumer takes the held beat this cycle
//   vld, dout  : registered slot state
//   free       : slot can take a new beat this cycle (empty or draining)
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout,
  output logic         free
);
  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    // Load wins over drain so a simultaneous drain+load keeps the slot full.
    if (vld_q && ready) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign dout = data_q;
  assign free = !vld_q || ready;
endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N stream demultiplexer, one holding slot per channel.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : stream_demux_if.slave (input stream + N output channels)
//   err_cnt    : saturating count of beats dropped for in_sel >= N
// Optional: STREAM_DEMUX_BROADCAST_EN adds bus.in_bcast, which loads every
// slot at once and stalls until all slots can take the beat.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  parameter int S = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_demux_if.slave        bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic [N-1:0]         free;
  logic [N-1:0]         load;
  logic [N-1:0]         v_all;
  logic [N*W-1:0]       d_all;
  logic                 in_ready_c;
  logic                 in_range;
  logic                 bcast;
  logic                 accept;
  logic                 err_inc;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .ready (bus.out_ready[k]),
      .din   (bus.in_data),
      .vld   (v_all[k]),
      .dout  (d_all[k*W +: W]),
      .free  (free[k])
    );
  end

`ifdef STREAM_DEMUX_BROADCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    // Out-of-range selects are always ready so the producer never stalls on them.
    in_ready_c = 1'b1;
    in_range   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == S'(k)) begin
        in_range   = 1'b1;
        in_ready_c = free[k];
      end
    end
    if (bcast) in_ready_c = &free;

    accept = bus.in_valid && in_ready_c;
    load   = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && (bcast || (bus.in_sel == S'(k)));
    end
    err_inc = accept && !bcast && !in_range;

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != ERR_CNT_MAX)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_all;
  assign bus.out_data  = d_all;
  assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed bench for stream_demux with a 4-channel and a
// 3-channel instance sharing clock and reset.
module tb_stream_demux;
  logic       clk;
  logic       reset;
  logic [7:0] err4, err3;
  int         passed;
  int         total;

  stream_demux_if #(.W(8), .N(4), .S(2)) if4 ();
  stream_demux_if #(.W(8), .N(3), .S(2)) if3 ();

  stream_demux #(.W(8), .N(4), .S(2)) dut4 (
    .clk(clk), .reset(reset), .bus(if4), .err_cnt(err4)
  );
  stream_demux #(.W(8), .N(3), .S(2)) dut3 (
    .clk(clk), .reset(reset), .bus(if3), .err_cnt(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    if4.in_data = '0; if4.in_sel = '0; if4.in_valid = 1'b0; if4.out_ready = '0;
    if3.in_data = '0; if3.in_sel = '0; if3.in_valid = 1'b0; if3.out_ready = 3'b111;
`ifdef STREAM_DEMUX_BROADCAST_EN
    if4.in_bcast = 1'b0;
    if3.in_bcast = 1'b0;
`endif
    #3;
    chk("rst_out_valid", 32'(if4.out_valid), 32'h0);
    chk("rst_err_cnt", 32'(err4), 32'h0);
    chk("rst_in_ready", 32'(if4.in_ready), 32'h1);
    tick;
    reset = 1'b0;

    // Streaming, back-to-back beats to channel 2
    if4.out_ready = 4'b1111;
    if4.in_valid = 1'b1; if4.in_sel = 2'd2; if4.in_data = 8'hA5;
    #1;
    chk("stream_ready0", 32'(if4.in_ready), 32'h1);
    tick;
    chk("stream_valid0", 32'(if4.out_valid), 32'h4);
    chk("stream_data0", 32'(if4.out_data[23:16]), 32'hA5);
    if4.in_data = 8'h5A;
    #1;
    chk("stream_ready1", 32'(if4.in_ready), 32'h1);
    tick;
    chk("stream_valid1", 32'(if4.out_valid), 32'h4);
    chk("stream_data1", 32'(if4.out_data[23:16]), 32'h5A);
    if4.in_valid = 1'b0;
    tick;
    chk("stream_empty", 32'(if4.out_valid), 32'h0);
    chk("stream_err", 32'(err4), 32'h0);

    // Backpressure on channel 1, channel 3 unaffected
    if4.out_ready = 4'b1101;
    if4.in_valid = 1'b1; if4.in_sel = 2'd1; if4.in_data = 8'h11;
    #1;
    chk("bp_ready_first", 32'(if4.in_ready), 32'h1);
    tick;
    chk("bp_valid_first", 32'(if4.out_valid), 32'h2);
    chk("bp_data_first", 32'(if4.out_data[15:8]), 32'h11);
    if4.in_sel = 2'd3; if4.in_data = 8'h33;
    #1;
    chk("bp_ready_ch3", 32'(if4.in_ready), 32'h1);
    tick;
    chk("bp_valid_ch3", 32'(if4.out_valid), 32'hA);
    chk("bp_data_ch3", 32'(if4.out_data[31:24]), 32'h33);
    if4.in_sel = 2'd1; if4.in_data = 8'h22;
    #1;
    chk("bp_stall", 32'(if4.in_ready), 32'h0);
    tick;
    chk("bp_valid_stall", 32'(if4.out_valid), 32'h2);
    chk("bp_data_held", 32'(if4.out_data[15:8]), 32'h11);
    if4.out_ready = 4'b1111;
    #1;
    chk("bp_ready_release", 32'(if4.in_ready), 32'h1);
    tick;
    chk("bp_valid_reload", 32'(if4.out_valid), 32'h2);
    chk("bp_data_reload", 32'(if4.out_data[15:8]), 32'h22);
    if4.in_valid = 1'b0;
    tick;
    chk("bp_empty", 32'(if4.out_valid), 32'h0);

    // Out-of-range selects on the 3-channel instance
    if3.in_valid = 1'b1; if3.in_sel = 2'd3; if3.in_data = 8'hEE;
    for (int i = 0; i < 300; i++) begin
      chk("oor_ready", 32'(if3.in_ready), 32'h1);
      tick;
      chk("oor_no_valid", 32'(if3.out_valid), 32'h0);
      if (i == 9) chk("oor_err_10", 32'(err3), 32'd10);
    end
    chk("oor_err_sat", 32'(err3), 32'd255);
    if3.in_valid = 1'b0;

    // Reset mid-traffic with channels 0 and 2 full
    if4.out_ready = 4'b0000;
    if4.in_valid = 1'b1; if4.in_sel = 2'd0; if4.in_data = 8'h01;
    tick;
    if4.in_sel = 2'd2; if4.in_data = 8'h02;
    tick;
    if4.in_sel = 2'd0;
    chk("mid_filled", 32'(if4.out_valid), 32'h5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(if4.out_valid), 32'h0);
    chk("mid_rst_err3", 32'(err3), 32'h0);
    chk("mid_rst_ready", 32'(if4.in_ready), 32'h1);
    chk("mid_rst_data", 32'(if4.out_data), 32'h0);
    if4.in_valid = 1'b0;
    tick;
    reset = 1'b0;
    if4.in_valid = 1'b1; if4.in_sel = 2'd0; if4.in_data = 8'h99;
    #1;
    chk("post_rst_ready", 32'(if4.in_ready), 32'h1);
    tick;
    chk("post_rst_valid", 32'(if4.out_valid), 32'h1);
    chk("post_rst_data", 32'(if4.out_data[7:0]), 32'h99);

`ifdef STREAM_DEMUX_BROADCAST_EN
    // Broadcast stalls on full slot 0, then loads every slot together
    if4.in_bcast = 1'b1; if4.in_data = 8'h3C; if4.out_ready = 4'b1110;
    #1;
    chk("bc_stall", 32'(if4.in_ready), 32'h0);
    tick;
    chk("bc_valid_stall", 32'(if4.out_valid), 32'h1);
    chk("bc_data_held", 32'(if4.out_data[7:0]), 32'h99);
    if4.out_ready = 4'b1111;
    #1;
    chk("bc_ready", 32'(if4.in_ready), 32'h1);
    tick;
    chk("bc_valid_all", 32'(if4.out_valid), 32'hF);
    chk("bc_data_all", if4.out_data, 32'h3C3C3C3C);
    chk("bc_err", 32'(err4), 32'h0);
    if4.in_bcast = 1'b0;
`endif
    if4.in_valid = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised 1-to-N stream demultiplexer with valid/ready handshake and one registered holding slot per output channel. It generalises the plain combinational 1-to-4 bit demux to W-bit data, N channels and backpressure. Out-of-range selects are discarded and counted. It sits between a single producer (e.g. a key/command decoder) and N independent consumers such as display or register-bank interfaces.

## Interface
- W, 8: data width in bits
- N, 4: number of output channels (2..16; need not be a power of two)
- S, 2: select width; S = clog2(N), minimum 1
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  W  input payload
- in_sel  in  S  destination channel index
- in_valid  in  1  producer offers a beat
- in_ready  out  1  block accepts the beat this cycle
- out_data  out  N*W  channel k payload at bits [k*W +: W]
- out_valid  out  N  channel k slot holds a beat
- out_ready  in  N  consumer k takes the beat this cycle
- err_cnt  out  8  saturating count of beats dropped for in_sel >= N

## Operation
- Each channel k has one slot: valid bit v[k] and data register d[k]. out_valid[k] = v[k]; out_data slice k = d[k].
- Drain k: v[k] && out_ready[k].
- in_ready is combinational:
  - in_sel < N: in_ready = !v[in_sel] || drain(in_sel).
  - in_sel >= N: in_ready = 1.
- in_ready does not depend on in_valid.
- Accept: in_valid && in_ready.
- Accept with in_sel = k < N:
  - d[k] <= in_data and v[k] <= 1 at the next edge.
  - A simultaneous drain of k reloads the slot; v[k] stays 1 with no bubble.
- Drain without a load into k: v[k] <= 0. d[k] holds its last value; it is don't-care while v[k] = 0.
- Accept with in_sel >= N:
  - The beat is discarded and no slot changes.
  - err_cnt increments by 1 and saturates at 255; it never wraps.
- Channels are independent. A full slot on one channel never blocks beats for another channel.
- out_data and out_valid are driven only from registers. There is no combinational path from in_* to out_*.
- Reset, asserted at any time including mid-transfer:
  - All v = 0, all d = 0, err_cnt = 0, immediately and asynchronously.
  - Beats held in slots are lost.
  - in_ready is 1 while reset is held, since all slots are empty.

## Timing
- Latency: a beat accepted at edge t is visible on out_valid/out_data right after edge t.
- Throughput: one beat per cycle per channel when its consumer holds out_ready = 1. Otherwise a channel accepts one beat per drain.
- Backpressure: with out_ready[k] = 0 and v[k] = 1, in_ready = 0 for in_sel = k.
- Handshake rules:
  - Producer must hold in_data and in_sel stable while in_valid = 1 and in_ready = 0.
  - Block holds out_data slice k stable while out_valid[k] = 1 and out_ready[k] = 0.
- Reset release: the first accept is possible in the first cycle after deassertion.

## Configuration
- Macro: STREAM_DEMUX_BROADCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - With in_bcast = 1, in_sel is ignored and in_ready = AND over all k of (!v[k] || drain(k)).
  - On accept, every slot loads in_data and sets v = 1 in the same edge.
  - err_cnt never increments for broadcast beats.
- Undefined:
  - in_bcast does not exist.
  - Behaviour is exactly the unicast description above.

## Structure
- Shared package stream_demux_pkg holds:
  - ERR_CNT_W = 8 and ERR_CNT_MAX = 255.
  - A clog2-style constant function for deriving S from N.
- Sub-module demux_slot: one channel's valid/data register with load, drain and reload logic. It is instantiated N times by a generate loop.
- Top level holds the in_ready mux, the out-of-range detector and err_cnt.

## Test plan
- Reset mid-traffic: fill channels 0 and 2, assert reset -> out_valid = 4'b0000, err_cnt = 0 and in_ready = 1 without waiting for a clock edge.
- Streaming: W = 8, N = 4, out_ready = 4'b1111, send 0xA5 to sel 2 -> out_valid = 4'b0100 and data 0xA5 one edge later; back-to-back beats show no bubbles.
- Backpressure:
  - out_ready[1] = 0, send 0x11 then 0x22 to sel 1 -> in_ready = 0 on the second beat.
  - Meanwhile a beat to sel 3 is accepted.
  - Raising out_ready[1] drains 0x11 and accepts 0x22 in the same cycle.
- Out of range: N = 3, S = 2, send 300 beats with sel = 3 -> in_ready = 1 throughout, no out_valid, err_cnt = 255.
- Broadcast (macro defined): in_bcast = 1, data 0x3C, out_ready[0] = 0 with slot 0 full -> stall. Release out_ready[0] -> all slots hold 0x3C, err_cnt unchanged.
